// File: rtl/xor_perceptron_net_if.sv
// Data bundle for the XOR perceptron network: binary inputs, runtime
// weights/biases toward the block, and registered sums/activation back out.
interface xor_perceptron_net_if #(
    parameter int WW = 8,
    parameter int SW = 10
);
    logic                 a1;
    logic                 a2;
    logic signed [WW-1:0] w1, w2, w3, w4, w5, w6;
    logic signed [WW-1:0] bias1, bias2, bias3;
    logic signed [SW-1:0] out1, out2, out3;
    logic                 a3;

    // Source side: drives activations and weights, observes results.
    modport master (
        output a1, a2, w1, w2, w3, w4, w5, w6, bias1, bias2, bias3,
        input  out1, out2, out3, a3
    );

    // Network side.
    modport slave (
        input  a1, a2, w1, w2, w3, w4, w5, w6, bias1, bias2, bias3,
        output out1, out2, out3, a3
    );
endinterface

// File: rtl/xor_perceptron_net.sv
// Two-layer, three-neuron perceptron with binary inputs and step activation.
// Stage 1 registers the hidden sums (N1, N2) and their activations h1/h2.
// Stage 2 registers the output neuron sum (N3) and its activation a3.
// SW must be at least WW+2 so that a three-term sum never wraps.
module xor_perceptron_net #(
    parameter int WW = 8,
    parameter int SW = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    xor_perceptron_net_if.slave  bus
);

    // Sign-extend a weight to sum width.
    function automatic logic signed [SW-1:0] sx(input logic [WW-1:0] w);
        return $signed({{(SW-WW){w[WW-1]}}, w});
    endfunction

    // Product with a 1-bit activation reduces to a select.
    function automatic logic signed [SW-1:0] term(input logic a, input logic [WW-1:0] w);
        return a ? sx(w) : '0;
    endfunction

    logic signed [SW-1:0] out1_q, out2_q, out3_q;
    logic signed [SW-1:0] out1_d, out2_d, out3_d;
    logic                 h1_q, h2_q, a3_q;
    logic                 h1_d, h2_d, a3_d;

    // Net sums and strictly-positive step activations for all three neurons.
    always_comb begin
        out1_d = term(bus.a1, bus.w1) + term(bus.a2, bus.w2) + sx(bus.bias1);
        out2_d = term(bus.a1, bus.w3) + term(bus.a2, bus.w4) + sx(bus.bias2);
        out3_d = term(h1_q, bus.w5) + term(h2_q, bus.w6) + sx(bus.bias3);
        h1_d   = (out1_d > 0);
        h2_d   = (out2_d > 0);
        a3_d   = (out3_d > 0);
    end

    // Both pipeline stages; synchronous reset clears everything in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out1_q <= '0;
            out2_q <= '0;
            out3_q <= '0;
            h1_q   <= 1'b0;
            h2_q   <= 1'b0;
            a3_q   <= 1'b0;
        end else begin
            out1_q <= out1_d;
            out2_q <= out2_d;
            h1_q   <= h1_d;
            h2_q   <= h2_d;
            out3_q <= out3_d;
            a3_q   <= a3_d;
        end
    end

    assign bus.out1 = out1_q;
    assign bus.out2 = out2_q;
    assign bus.out3 = out3_q;
    assign bus.a3   = a3_q;

endmodule

// File: tb/tb_xor_perceptron_net.sv
// Bench for xor_perceptron_net: integer reference model of the two-stage
// network, fixed XOR vector table, extremes, random streams and reset pulses.
module tb_xor_perceptron_net;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    xor_perceptron_net_if bus ();

    xor_perceptron_net dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Stimulus state: weights w[0..5] = w1..w6, biases b[0..2] = bias1..bias3.
    int wv [6];
    int bv [3];
    int a1v, a2v;

    // Reference model state (plain integer arithmetic).
    int m_out1, m_out2, m_out3, m_h1, m_h2, m_a3;

    typedef struct {
        int a1;
        int a2;
        int e_out1;
        int e_out2;
        int e_out3;
        int e_a3;
    } vec_t;
    vec_t xor_tab [4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic drive();
        bus.a1    = a1v[0];
        bus.a2    = a2v[0];
        bus.w1    = 8'(wv[0]);
        bus.w2    = 8'(wv[1]);
        bus.w3    = 8'(wv[2]);
        bus.w4    = 8'(wv[3]);
        bus.w5    = 8'(wv[4]);
        bus.w6    = 8'(wv[5]);
        bus.bias1 = 8'(bv[0]);
        bus.bias2 = 8'(bv[1]);
        bus.bias3 = 8'(bv[2]);
    endtask

    task automatic set_xor_weights();
        wv[0] = 5;   wv[1] = 5;
        wv[2] = -7;  wv[3] = -7;
        wv[4] = -11; wv[5] = -11;
        bv[0] = -8;  bv[1] = 3;  bv[2] = 6;
    endtask

    task automatic randomize_all();
        for (int i = 0; i < 6; i++) wv[i] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < 3; i++) bv[i] = int'($urandom_range(255)) - 128;
        a1v = int'($urandom_range(1));
        a2v = int'($urandom_range(1));
    endtask

    // Advance the model by one edge with the currently driven inputs, clock
    // the DUT, then compare every output against the model.
    task automatic tick(input string tag);
        drive();
        if (!reset_n) begin
            m_out1 = 0; m_out2 = 0; m_out3 = 0;
            m_h1 = 0;   m_h2 = 0;   m_a3 = 0;
        end else begin
            m_out3 = wv[4] * m_h1 + wv[5] * m_h2 + bv[2];
            m_a3   = (m_out3 > 0) ? 1 : 0;
            m_out1 = wv[0] * a1v + wv[1] * a2v + bv[0];
            m_out2 = wv[2] * a1v + wv[3] * a2v + bv[1];
            m_h1   = (m_out1 > 0) ? 1 : 0;
            m_h2   = (m_out2 > 0) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".out1"}, int'(bus.out1), m_out1);
        chk({tag, ".out2"}, int'(bus.out2), m_out2);
        chk({tag, ".out3"}, int'(bus.out3), m_out3);
        chk({tag, ".a3"},   int'(bus.a3),   m_a3);
    endtask

    initial begin
        int hist [$];
        int since_rst;

        xor_tab[0] = '{1, 1,  2, -11, -5, 0};
        xor_tab[1] = '{1, 0, -3,  -4,  6, 1};
        xor_tab[2] = '{0, 1, -3,  -4,  6, 1};
        xor_tab[3] = '{0, 0, -8,   3, -5, 0};

        m_out1 = 0; m_out2 = 0; m_out3 = 0;
        m_h1 = 0;   m_h2 = 0;   m_a3 = 0;

        // 1: reset held for two edges with random inputs.
        reset_n = 1'b0;
        randomize_all();
        tick("reset0");
        randomize_all();
        tick("reset1");
        chk("reset_out1_zero", int'(bus.out1), 0);
        chk("reset_a3_zero",   int'(bus.a3),   0);

        // 2: all-zero weights, both inputs high: zero sums do not fire.
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) wv[i] = 0;
        for (int i = 0; i < 3; i++) bv[i] = 0;
        a1v = 1; a2v = 1;
        for (int i = 0; i < 3; i++) tick("zerow");
        chk("zerow_out3", int'(bus.out3), 0);
        chk("zerow_a3",   int'(bus.a3),   0);

        // 3: XOR weights, each input pair held for 5 cycles, checked against table.
        set_xor_weights();
        for (int v = 0; v < 4; v++) begin
            a1v = xor_tab[v].a1;
            a2v = xor_tab[v].a2;
            tick("xor_first");
            // First cycle: hidden sums are new, output neuron still reflects prior pair.
            chk("xor_lag_out1", int'(bus.out1), xor_tab[v].e_out1);
            if (v > 0) chk("xor_lag_out3", int'(bus.out3), xor_tab[v-1].e_out3);
            for (int c = 1; c < 5; c++) tick("xor_hold");
            chk("xor_tab_out1", int'(bus.out1), xor_tab[v].e_out1);
            chk("xor_tab_out2", int'(bus.out2), xor_tab[v].e_out2);
            chk("xor_tab_out3", int'(bus.out3), xor_tab[v].e_out3);
            chk("xor_tab_a3",   int'(bus.a3),   xor_tab[v].e_a3);
        end

        // 4: extremes, no wrap in the 10-bit sums.
        wv[0] = 127;  wv[1] = 127;  bv[0] = 127;
        wv[2] = -128; wv[3] = -128; bv[1] = -128;
        a1v = 1; a2v = 1;
        tick("extreme");
        chk("extreme_out1_max", int'(bus.out1), 381);
        chk("extreme_out2_min", int'(bus.out2), -384);
        tick("extreme2");

        // 5: back-to-back random XOR vectors; a3 must equal XOR from two edges back.
        set_xor_weights();
        hist.delete();
        for (int i = 0; i < 60; i++) begin
            a1v = int'($urandom_range(1));
            a2v = int'($urandom_range(1));
            hist.push_back(a1v ^ a2v);
            tick("b2b");
            if (hist.size() >= 2) chk("b2b_xor_lat2", int'(bus.a3), hist[hist.size()-2]);
        end

        // Fully random weights and inputs every cycle, with occasional reset.
        for (int i = 0; i < 300; i++) begin
            randomize_all();
            reset_n = ($urandom_range(19) == 0) ? 1'b0 : 1'b1;
            tick("rand");
        end
        reset_n = 1'b1;

        // 6: one-cycle reset pulse in an XOR stream; correct again 2 edges after release.
        set_xor_weights();
        a1v = 1; a2v = 0;
        tick("pulse_pre");
        tick("pulse_pre");
        reset_n = 1'b0;
        tick("pulse_rst");
        chk("pulse_rst_out1", int'(bus.out1), 0);
        chk("pulse_rst_a3",   int'(bus.a3),   0);
        reset_n = 1'b1;
        since_rst = 0;
        a1v = 0; a2v = 1;
        tick("pulse_rel");
        chk("pulse_rel_out1", int'(bus.out1), -3);
        tick("pulse_rel");
        chk("pulse_rel2_a3",   int'(bus.a3),   1);
        chk("pulse_rel2_out3", int'(bus.out3), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
